// File: rtl/piso.sv
// Parallel-in serial-out transmitter: AXI4-Lite writes fill a FIFO that is shifted out MSB-first on sout.
// Optional feature: define PISO_IRQ_EN to add the irq output and the interrupt-enable register at 0x18.

module piso #(
   parameter int PISO_WIDTH     = 8,
   parameter int PISO_DEPTH     = 16,
   parameter int AXI4_ADDR_BITS = 32,
   parameter int AXI4_DATA_BITS = 32,
   parameter int AXI4_STRB_BITS = AXI4_DATA_BITS / 8,
   parameter int AXI4_PROT_BITS = 3,
   parameter int AXI4_RESP_BITS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      sout,
   output logic                      sout_valid,
   output logic                      s_axi4lite_aw_ready,
   input  logic                      s_axi4lite_aw_valid,
   input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
   input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,
   output logic                      s_axi4lite_w_ready,
   input  logic                      s_axi4lite_w_valid,
   input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
   input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,
   input  logic                      s_axi4lite_b_ready,
   output logic                      s_axi4lite_b_valid,
   output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,
   output logic                      s_axi4lite_ar_ready,
   input  logic                      s_axi4lite_ar_valid,
   input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
   input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,
   input  logic                      s_axi4lite_r_ready,
   output logic                      s_axi4lite_r_valid,
   output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
   output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
`ifdef PISO_IRQ_EN
   ,
   output logic                      irq
`endif
);

   localparam int PTR_W = $clog2(PISO_DEPTH);
   localparam int CNT_W = $clog2(PISO_WIDTH);
   localparam logic [PTR_W:0]              FIFO_FULL_CNT = (PTR_W+1)'(PISO_DEPTH);
   localparam logic [CNT_W-1:0]            LAST_BIT      = CNT_W'(PISO_WIDTH - 1);
   localparam logic [AXI4_RESP_BITS-1:0]   RESP_OKAY     = '0;
   localparam logic [AXI4_RESP_BITS-1:0]   RESP_SLVERR   = AXI4_RESP_BITS'(2);
   localparam logic [7:0]                  ADDR_DATA     = 8'h00;
   localparam logic [7:0]                  ADDR_STATUS   = 8'h08;
   localparam logic [7:0]                  ADDR_CTRL     = 8'h10;
`ifdef PISO_IRQ_EN
   localparam logic [7:0]                  ADDR_IE       = 8'h18;
`endif

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   logic                      aw_held, w_held, rd_req;
   logic [7:0]                aw_addr_q, ar_addr_q;
   logic [AXI4_DATA_BITS-1:0] w_data_q;
   logic                      en, user_rstn;
   logic [PISO_WIDTH-1:0]     fifo_mem [PISO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [PTR_W:0]            count;
   logic                      fifo_empty, fifo_full;
   state_t                    state, state_next;
   logic [PISO_WIDTH-1:0]     shreg;
   logic [CNT_W-1:0]          bit_cnt;
   logic                      load, shift, pop, busy;
   logic                      wr_fire, push_ok, ctrl_wr, fifo_room;
   logic [AXI4_RESP_BITS-1:0] wr_resp, rd_resp_next;
   logic [AXI4_DATA_BITS-1:0] rd_data_next;
   logic                      unused;
`ifdef PISO_IRQ_EN
   logic                      ie, ie_wr;
`endif

   assign unused = &{1'b0, s_axi4lite_aw_addr, s_axi4lite_ar_addr, s_axi4lite_aw_prot,
                     s_axi4lite_ar_prot, s_axi4lite_w_strb, w_data_q};

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FIFO_FULL_CNT);
   assign busy       = (state != IDLE);

   assign s_axi4lite_aw_ready = !aw_held && !s_axi4lite_b_valid;
   assign s_axi4lite_w_ready  = !w_held && !s_axi4lite_b_valid;
   assign s_axi4lite_ar_ready = !rd_req && !s_axi4lite_r_valid;

   // A simultaneous pop frees a slot, so a full FIFO can still accept a push on that edge.
   assign fifo_room = user_rstn && (!fifo_full || pop);
   assign wr_fire   = aw_held && w_held && !s_axi4lite_b_valid;
   assign push_ok   = wr_fire && (aw_addr_q == ADDR_DATA) && fifo_room;
   assign ctrl_wr   = wr_fire && (aw_addr_q == ADDR_CTRL);
`ifdef PISO_IRQ_EN
   assign ie_wr     = wr_fire && (aw_addr_q == ADDR_IE);
`endif

   always_comb begin
      wr_resp = RESP_SLVERR;
      case (aw_addr_q)
         ADDR_DATA: wr_resp = fifo_room ? RESP_OKAY : RESP_SLVERR;
         ADDR_CTRL: wr_resp = RESP_OKAY;
`ifdef PISO_IRQ_EN
         ADDR_IE:   wr_resp = RESP_OKAY;
`endif
         default:   wr_resp = RESP_SLVERR;
      endcase
   end

   always_comb begin
      rd_data_next = '0;
      rd_resp_next = RESP_SLVERR;
      case (ar_addr_q)
         ADDR_STATUS: begin
            rd_data_next[4:0] = {busy, en, user_rstn, fifo_full, fifo_empty};
            rd_resp_next      = RESP_OKAY;
         end
         ADDR_CTRL: begin
            rd_data_next[1:0] = {user_rstn, en};
            rd_resp_next      = RESP_OKAY;
         end
`ifdef PISO_IRQ_EN
         ADDR_IE: begin
            rd_data_next[0] = ie;
            rd_resp_next    = RESP_OKAY;
         end
`endif
         default: begin
            rd_data_next = '0;
            rd_resp_next = RESP_SLVERR;
         end
      endcase
   end

   // AW and W are held independently; the write commits one edge after both are present.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held            <= 1'b0;
         w_held             <= 1'b0;
         aw_addr_q          <= '0;
         w_data_q           <= '0;
         s_axi4lite_b_valid <= 1'b0;
         s_axi4lite_b_resp  <= '0;
         rd_req             <= 1'b0;
         ar_addr_q          <= '0;
         s_axi4lite_r_valid <= 1'b0;
         s_axi4lite_r_data  <= '0;
         s_axi4lite_r_resp  <= '0;
         en                 <= 1'b1;
         user_rstn          <= 1'b1;
      end else begin
         if (s_axi4lite_aw_valid && s_axi4lite_aw_ready) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi4lite_aw_addr[7:0];
         end
         if (s_axi4lite_w_valid && s_axi4lite_w_ready) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi4lite_w_data;
         end
         if (wr_fire) begin
            aw_held            <= 1'b0;
            w_held             <= 1'b0;
            s_axi4lite_b_valid <= 1'b1;
            s_axi4lite_b_resp  <= wr_resp;
            if (ctrl_wr) begin
               en        <= w_data_q[0];
               user_rstn <= w_data_q[1];
            end
         end else if (s_axi4lite_b_valid && s_axi4lite_b_ready) begin
            s_axi4lite_b_valid <= 1'b0;
         end

         if (s_axi4lite_ar_valid && s_axi4lite_ar_ready) begin
            rd_req    <= 1'b1;
            ar_addr_q <= s_axi4lite_ar_addr[7:0];
         end
         if (rd_req) begin
            rd_req             <= 1'b0;
            s_axi4lite_r_valid <= 1'b1;
            s_axi4lite_r_data  <= rd_data_next;
            s_axi4lite_r_resp  <= rd_resp_next;
         end else if (s_axi4lite_r_valid && s_axi4lite_r_ready) begin
            s_axi4lite_r_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= w_data_q[PISO_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !user_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)      count <= count + (PTR_W+1)'(1);
         else if (!push_ok && pop) count <= count - (PTR_W+1)'(1);
      end
   end

   // The load happens on the transition into SHIFT (or at the last bit) so the MSB is on sout
   // the cycle after the word becomes visible, and consecutive words run without a gap.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift      = 1'b0;
      pop        = 1'b0;
      if (!user_rstn) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en && !fifo_empty) begin
                  pop        = 1'b1;
                  load       = 1'b1;
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  if (en && !fifo_empty) begin
                     pop  = 1'b1;
                     load = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  shift = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            shreg   <= fifo_mem[rd_ptr];
            bit_cnt <= '0;
         end else if (shift) begin
            shreg   <= {shreg[PISO_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

   assign sout_valid = (state == SHIFT) && user_rstn;
   assign sout       = sout_valid && shreg[PISO_WIDTH-1];

`ifdef PISO_IRQ_EN
   // Uses the next state so irq rises on the cycle right after the final LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         ie  <= 1'b0;
         irq <= 1'b0;
      end else begin
         if (ie_wr) ie <= w_data_q[0];
         irq <= ie && fifo_empty && (state_next == IDLE) && user_rstn;
      end
   end
`endif

endmodule
